// File: rtl/arm_shift_pipe_if.sv
// rtl/arm_shift_pipe_if.sv - operand/result handshake bus for arm_shift_pipe
// ARM_SHIFT_ROTIMM_EN adds in_rotimm (rotated 8-bit immediate select).
interface arm_shift_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_oper;
  logic [1:0]        in_type;
  logic              in_imm;
  logic [7:0]        in_amt;
  logic              in_cflag;
  logic [TAG_W-1:0]  in_tag;
`ifdef ARM_SHIFT_ROTIMM_EN
  logic              in_rotimm;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_res;
  logic              out_cflag;
  logic [TAG_W-1:0]  out_tag;

`ifdef ARM_SHIFT_ROTIMM_EN
  modport slave (
    input  flush, in_valid, in_oper, in_type, in_imm, in_amt, in_cflag, in_tag, in_rotimm,
    input  out_ready,
    output in_ready, out_valid, out_res, out_cflag, out_tag
  );
  modport master (
    output flush, in_valid, in_oper, in_type, in_imm, in_amt, in_cflag, in_tag, in_rotimm,
    output out_ready,
    input  in_ready, out_valid, out_res, out_cflag, out_tag
  );
`else
  modport slave (
    input  flush, in_valid, in_oper, in_type, in_imm, in_amt, in_cflag, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_res, out_cflag, out_tag
  );
  modport master (
    output flush, in_valid, in_oper, in_type, in_imm, in_amt, in_cflag, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_res, out_cflag, out_tag
  );
`endif
endinterface

// File: rtl/arm_shift_pipe.sv
// rtl/arm_shift_pipe.sv - pipelined ARM operand shifter (LSL/LSR/ASR/ROR/RRX) with carry-out
// Define ARM_SHIFT_ROTIMM_EN to add the rotated 8-bit immediate mode selected by in_rotimm.
module arm_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  arm_shift_pipe_if.slave  bus
);
  localparam int             LW = $clog2(DATA_W);
  localparam logic [7:0]     W8 = 8'(DATA_W);
  localparam logic [LW:0]    WL = (LW+1)'(DATA_W);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  sh_type_e            w_type;
  logic [7:0]          w_amt;
  logic [7:0]          w_asr_amt;
  logic                w_rrx;
  logic [LW-1:0]       w_ror_sh;
  logic [DATA_W:0]     w_lsl;
  logic [DATA_W:0]     w_lsr;
  logic [DATA_W:0]     w_asr;
  logic [DATA_W-1:0]   w_ror;
  logic [DATA_W-1:0]   w_res;
  logic                w_c;
  logic                w_adv;
  logic                w_take;

  logic [STAGES-1:0]   r_vld;
  logic [DATA_W-1:0]   r_res [STAGES];
  logic                r_c   [STAGES];
  logic [TAG_W-1:0]    r_tag [STAGES];

  assign w_type = sh_type_e'(bus.in_type);

  // Immediate zero re-encodes: LSR/ASR #0 mean #W, ROR #0 means RRX.
  always_comb begin
    w_rrx = 1'b0;
    w_amt = bus.in_amt;
    if (bus.in_imm) begin
      w_amt           = '0;
      w_amt[LW-1:0]   = bus.in_amt[LW-1:0];
      if (w_amt == 8'd0) begin
        if (w_type == SH_LSR || w_type == SH_ASR) begin
          w_amt = W8;
        end else if (w_type == SH_ROR) begin
          w_rrx = 1'b1;
        end
      end
    end
  end

  // One extra bit beside the operand captures the last bit shifted out as carry.
  assign w_lsl     = {1'b0, bus.in_oper} << w_amt;
  assign w_lsr     = {bus.in_oper, 1'b0} >> w_amt;
  assign w_asr_amt = (w_amt > W8) ? W8 : w_amt;
  assign w_asr     = $unsigned($signed({bus.in_oper, 1'b0}) >>> w_asr_amt);
  assign w_ror_sh  = w_amt[LW-1:0];
  assign w_ror     = (bus.in_oper >> w_ror_sh) | (bus.in_oper << (WL - {1'b0, w_ror_sh}));

`ifdef ARM_SHIFT_ROTIMM_EN
  logic [DATA_W-1:0] w_imm8;
  logic [LW-1:0]     w_ri_sh;
  logic [DATA_W-1:0] w_ri_rot;

  always_comb begin
    w_imm8      = '0;
    w_imm8[7:0] = bus.in_oper[7:0];
  end

  assign w_ri_sh  = LW'({bus.in_amt[3:0], 1'b0});
  assign w_ri_rot = (w_imm8 >> w_ri_sh) | (w_imm8 << (WL - {1'b0, w_ri_sh}));
`endif

  always_comb begin
    w_res = bus.in_oper;
    w_c   = bus.in_cflag;
`ifdef ARM_SHIFT_ROTIMM_EN
    if (bus.in_rotimm) begin
      w_res = w_ri_rot;
      w_c   = (bus.in_amt[3:0] == 4'd0) ? bus.in_cflag : w_ri_rot[DATA_W-1];
    end else
`endif
    if (w_rrx) begin
      w_res = {bus.in_cflag, bus.in_oper[DATA_W-1:1]};
      w_c   = bus.in_oper[0];
    end else if (w_amt != 8'd0) begin
      unique case (w_type)
        SH_LSL: begin
          w_res = w_lsl[DATA_W-1:0];
          w_c   = w_lsl[DATA_W];
        end
        SH_LSR: begin
          w_res = w_lsr[DATA_W:1];
          w_c   = w_lsr[0];
        end
        SH_ASR: begin
          w_res = w_asr[DATA_W:1];
          w_c   = w_asr[0];
        end
        SH_ROR: begin
          w_res = w_ror;
          w_c   = w_ror[DATA_W-1];
        end
      endcase
    end
  end

  assign w_adv        = !r_vld[STAGES-1] | bus.out_ready;
  assign w_take       = bus.in_valid & w_adv & !bus.flush;
  assign bus.in_ready = w_adv;

  // Data registers load only with a valid entry so bubbles leave outputs holding.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_res[i] <= '0;
        r_c[i]   <= 1'b0;
        r_tag[i] <= '0;
      end
    end else if (bus.flush) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= bus.in_valid;
      if (w_take) begin
        r_res[0] <= w_res;
        r_c[0]   <= w_c;
        r_tag[0] <= bus.in_tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_res[i] <= r_res[i-1];
          r_c[i]   <= r_c[i-1];
          r_tag[i] <= r_tag[i-1];
        end
      end
    end
  end

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_res   = r_res[STAGES-1];
  assign bus.out_cflag = r_c[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];
endmodule
